// File: rtl/tdm_demux_deser_pkg.sv
// Shared definitions for the TDM receive deserializer and its transmitter.
// Holds the default word geometry and the frame length helper. When
// TDM_PARITY_EN is defined, each frame carries one extra slot (index WIDTH)
// holding even parity over the data bits. Bits are sent LSB first: slot k
// maps to word bit k.
package tdm_demux_deser_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SEL_W = 4;

`ifdef TDM_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  // Number of slots in one frame (data slots plus optional parity slot).
  function automatic int frame_len(input int width);
    return width + PAR_BITS;
  endfunction

endpackage

// File: rtl/tdm_demux_deser_demux_dec.sv
// demux_dec: one-hot write-enable decoder for the shadow register.
// Ports:
//   slot - slot index being written this cycle
//   en   - write qualifier (bit valid and slot is a data slot)
//   we   - one-hot per-bit write enables, all zero when en=0
module demux_dec #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 4
) (
  input  logic [SEL_W-1:0] slot,
  input  logic             en,
  output logic [WIDTH-1:0] we
);

  always_comb begin
    we = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (en && (slot == SEL_W'(k))) we[k] = 1'b1;
    end
  end

endmodule

// File: rtl/tdm_demux_deser.sv
// tdm_demux_deser: receive end of a 16:1 time-division mux link.
// Each valid serial bit is steered into slot `sel` of a shadow register;
// when the last slot arrives the rebuilt word is offered on a valid/ready
// output. Framing (sof mid-frame) and overrun faults are sticky flags.
// Optional feature macro: TDM_PARITY_EN adds an even-parity slot after the
// data bits and a sticky parity_err output.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   din, din_valid, sof  - serial bit, its qualifier, start-of-frame marker
//   dout, dout_valid     - reassembled word and its valid flag
//   dout_ready           - consumer accepts dout this cycle
//   sel                  - slot index the next bit will be written to
//   frame_err, overrun   - sticky fault flags
//   clr_err              - synchronous clear of the sticky flags
//   parity_err           - sticky parity fault (TDM_PARITY_EN only)
module tdm_demux_deser
  import tdm_demux_deser_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEL_W = DEF_SEL_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      din,
  input  logic                      din_valid,
  input  logic                      sof,
  output logic [WIDTH-1:0]          dout,
  output logic                      dout_valid,
  input  logic                      dout_ready,
  output logic [SEL_W+PAR_BITS-1:0] sel,
  output logic                      frame_err,
  output logic                      overrun,
  input  logic                      clr_err
`ifdef TDM_PARITY_EN
  ,
  output logic                      parity_err
`endif
);

  localparam int CNT_W = SEL_W + PAR_BITS;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(frame_len(WIDTH) - 1);

  logic [CNT_W-1:0] slot;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] we;
  logic [WIDTH-1:0] word;
  logic             data_slot;
  logic             complete;
  logic             word_ok;
  logic             mid_sof;
  logic             load;
  logic             drop_full;
  logic             xfer;

  always_comb begin
    // sof forces the bit into slot 0 regardless of where the counter is.
    slot      = sof ? '0 : sel;
    mid_sof   = din_valid && sof && (sel != '0);
    complete  = din_valid && (slot == LAST);
`ifdef TDM_PARITY_EN
    data_slot = (slot != LAST);
    word_ok   = ~((^shadow) ^ din);
`else
    data_slot = 1'b1;
    word_ok   = 1'b1;
`endif
    // Shadow with this cycle's write already applied, so the final data
    // bit can be delivered in the same edge it arrives.
    for (int k = 0; k < WIDTH; k++) begin
      word[k] = we[k] ? din : shadow[k];
    end
    xfer      = dout_valid && dout_ready;
    load      = complete && word_ok && (!dout_valid || dout_ready);
    drop_full = complete && word_ok && dout_valid && !dout_ready;
  end

  demux_dec #(
    .WIDTH (WIDTH),
    .SEL_W (SEL_W)
  ) u_dec (
    .slot (slot[SEL_W-1:0]),
    .en   (din_valid && data_slot),
    .we   (we)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel        <= '0;
      shadow     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      for (int k = 0; k < WIDTH; k++) begin
        if (we[k]) shadow[k] <= din;
      end
      if (din_valid) sel <= (slot == LAST) ? '0 : slot + 1'b1;
      if (load) begin
        dout       <= word;
        dout_valid <= 1'b1;
      end else if (xfer) begin
        dout_valid <= 1'b0;
      end
      frame_err <= mid_sof | (frame_err & ~clr_err);
      overrun   <= drop_full | (overrun & ~clr_err);
    end
  end

`ifdef TDM_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_err <= 1'b0;
    else        parity_err <= (complete && !word_ok) | (parity_err & ~clr_err);
  end
`endif

endmodule
